vend_sequencer: RTL



---
 rtl/vend_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: credit, drink dispensing and one-coin-at-a-time change return.
// Optional macro VEND_AUTO_CHANGE_EN returns leftover credit automatically after each drink.
module vend_sequencer #(
  parameter int JUICE_PRICE  = 25,
  parameter int COFFEE_PRICE = 20,
  parameter int MAX_BALANCE  = 99,
  parameter int DROP_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       money_1,
  input  logic       money_5,
  input  logic       money_10,
  input  logic       juice,
  input  logic       coffee,
  input  logic       cancel,
  output logic [6:0] balance,
  output logic [3:0] bal_tens,
  output logic [3:0] bal_ones,
  output logic       drop_juice,
  output logic       drop_coffee,
  output logic [2:0] coin_out,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       busy
);

  localparam int CNT_W = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DISPENSE, CHG_ON, CHG_GAP} state_e;

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [6:0]       bal_d;
  logic             drop_juice_d, drop_coffee_d, coin_reject_d, insufficient_d;
  logic [2:0]       coin_out_d;
  logic [2:0]       chg_coin;
  logic [6:0]       chg_val;
  logic [6:0]       coin_val;
  logic [7:0]       coin_sum;
  logic             coin_in;

  // Greedy choice of the next returned coin gives the minimum coin count.
  always_comb begin
    chg_coin = 3'b000;
    chg_val  = 7'd0;
    if (balance >= 7'd10) begin
      chg_coin = 3'b100;
      chg_val  = 7'd10;
    end else if (balance >= 7'd5) begin
      chg_coin = 3'b010;
      chg_val  = 7'd5;
    end else if (balance != 7'd0) begin
      chg_coin = 3'b001;
      chg_val  = 7'd1;
    end
  end

  assign coin_in  = money_1 | money_5 | money_10;
  assign coin_val = money_10 ? 7'd10 : (money_5 ? 7'd5 : 7'd1);
  assign coin_sum = {1'b0, balance} + {1'b0, coin_val};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    bal_d          = balance;
    drop_juice_d   = drop_juice;
    drop_coffee_d  = drop_coffee;
    coin_out_d     = coin_out;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (cancel) begin
          if (balance != 7'd0) begin
            state_d    = CHG_ON;
            coin_out_d = chg_coin;
            bal_d      = balance - chg_val;
          end
        end else if (coffee) begin
          if (balance >= 7'(COFFEE_PRICE)) begin
            bal_d         = balance - 7'(COFFEE_PRICE);
            drop_coffee_d = 1'b1;
            state_d       = DISPENSE;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (juice) begin
          if (balance >= 7'(JUICE_PRICE)) begin
            bal_d        = balance - 7'(JUICE_PRICE);
            drop_juice_d = 1'b1;
            state_d      = DISPENSE;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_in) begin
          if (coin_sum <= 8'(MAX_BALANCE)) bal_d = coin_sum[6:0];
          else                             coin_reject_d = 1'b1;
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_in;
        if (cnt == CNT_LAST) begin
          cnt_d         = '0;
          drop_juice_d  = 1'b0;
          drop_coffee_d = 1'b0;
          state_d       = IDLE;
`ifdef VEND_AUTO_CHANGE_EN
          if (balance != 7'd0) begin
            state_d    = CHG_ON;
            coin_out_d = chg_coin;
            bal_d      = balance - chg_val;
          end
`endif
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      CHG_ON: begin
        coin_reject_d = coin_in;
        if (cnt == CNT_LAST) begin
          cnt_d      = '0;
          coin_out_d = 3'b000;
          state_d    = CHG_GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      CHG_GAP: begin
        coin_reject_d = coin_in;
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (balance != 7'd0) begin
            state_d    = CHG_ON;
            coin_out_d = chg_coin;
            bal_d      = balance - chg_val;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      balance      <= 7'd0;
      drop_juice   <= 1'b0;
      drop_coffee  <= 1'b0;
      coin_out     <= 3'b000;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      balance      <= bal_d;
      drop_juice   <= drop_juice_d;
      drop_coffee  <= drop_coffee_d;
      coin_out     <= coin_out_d;
      coin_reject  <= coin_reject_d;
      insufficient <= insufficient_d;
      busy         <= (state_d != IDLE);
    end
  end

  assign bal_tens = 4'(balance / 7'd10);
  assign bal_ones = 4'(balance % 7'd10);

endmodule
